helm_mem_arb: RTL and testbench

Two-port arbiter and sequencer for the shared user-memory bus (page/offset byte space) behind the UART host. It takes single-byte read/write requests from two masters, port 0 (UART message engine) and port 1 (secondary host or internal agent), and grants them round-robin. For each granted request it issues exactly one transaction on the memory bus, waits for the memory acknowledge or a timeout, then returns the result to the owning master.

---
 rtl/helm_mem_arb.sv | 128 ++++++++++++
 tb/tb_helm_mem_arb.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/helm_mem_arb.sv
// helm_mem_arb: round-robin two-port arbiter sequencing single-byte transactions
// onto the shared user-memory bus, with ack timeout and registered outputs.
module helm_mem_arb #(
   parameter int         TIMEOUT_CYC = 255,
   parameter int         TO_CNT_BIT  = 16,
   parameter logic [7:0] TO_RD_DATA  = 8'hFF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       m0_req,
   input  logic       m0_wr,
   input  logic [7:0] m0_page,
   input  logic [7:0] m0_offset,
   input  logic [7:0] m0_wr_data,
   input  logic [7:0] m0_wr_msk,
   output logic       m0_ack,
   output logic       m0_err,
   output logic [7:0] m0_rd_data,
   input  logic       m1_req,
   input  logic       m1_wr,
   input  logic [7:0] m1_page,
   input  logic [7:0] m1_offset,
   input  logic [7:0] m1_wr_data,
   input  logic [7:0] m1_wr_msk,
   output logic       m1_ack,
   output logic       m1_err,
   output logic [7:0] m1_rd_data,
   output logic       mem_cs,
   output logic [7:0] mem_page,
   output logic [7:0] mem_offset,
   output logic       mem_wr_en,
   output logic [7:0] mem_wr_data,
   output logic [7:0] mem_wr_msk,
   output logic       mem_rd_en,
   input  logic [7:0] mem_rd_data,
   input  logic       mem_ack,
   output logic       busy,
   output logic       grant
);
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
   state_t                r_state, w_next;
   logic [TO_CNT_BIT-1:0] r_cnt;
   logic                  r_grant, r_wr, r_cs, r_wr_en, r_rd_en, r_busy;
   logic [7:0]            r_page, r_offset, r_wdata, r_wmsk;
   logic [1:0]            r_ack, r_err;
   logic [1:0][7:0]       r_rd;
   logic                  w_any, w_pick, w_wr, w_to, w_fin;
   logic [7:0]            w_rdv;
   assign w_any  = m0_req | m1_req;
   // on a tie the port that did not own the last transaction wins
   assign w_pick = (m0_req & m1_req) ? ~r_grant : m1_req;
   assign w_wr   = w_pick ? m1_wr : m0_wr;
   assign w_to   = r_cnt == TO_CNT_BIT'(TIMEOUT_CYC);
   assign w_fin  = mem_ack | w_to;
   assign w_rdv  = mem_ack ? mem_rd_data : TO_RD_DATA;
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = w_any ? S_ISSUE : S_IDLE;
         S_ISSUE: w_next = S_WAIT;
         S_WAIT:  w_next = w_fin ? S_DONE : S_WAIT;
         default: w_next = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt    <= '0;
         r_grant  <= 1'b1;
         r_wr     <= 1'b0;
         r_cs     <= 1'b0;
         r_wr_en  <= 1'b0;
         r_rd_en  <= 1'b0;
         r_busy   <= 1'b0;
         r_page   <= '0;
         r_offset <= '0;
         r_wdata  <= '0;
         r_wmsk   <= '0;
         r_ack    <= '0;
         r_err    <= '0;
         r_rd     <= '0;
      end else begin
         r_wr_en <= 1'b0;
         r_rd_en <= 1'b0;
         r_ack   <= '0;
         r_err   <= '0;
         case (r_state)
            S_IDLE: if (w_any) begin
               r_grant  <= w_pick;
               r_wr     <= w_wr;
               r_page   <= w_pick ? m1_page : m0_page;
               r_offset <= w_pick ? m1_offset : m0_offset;
               r_wdata  <= w_pick ? m1_wr_data : m0_wr_data;
               r_wmsk   <= w_pick ? m1_wr_msk : m0_wr_msk;
               r_cs     <= 1'b1;
               r_busy   <= 1'b1;
               r_wr_en  <= w_wr;
               r_rd_en  <= ~w_wr;
            end
            S_ISSUE: r_cnt <= '0;
            S_WAIT: if (w_fin) begin
               r_cs           <= 1'b0;
               r_ack[r_grant] <= 1'b1;
               r_err[r_grant] <= ~mem_ack;
               if (!r_wr) r_rd[r_grant] <= w_rdv;
            end else r_cnt <= r_cnt + TO_CNT_BIT'(1);
            default: r_busy <= 1'b0;
         endcase
      end
   end
   assign m0_ack      = r_ack[0];
   assign m1_ack      = r_ack[1];
   assign m0_err      = r_err[0];
   assign m1_err      = r_err[1];
   assign m0_rd_data  = r_rd[0];
   assign m1_rd_data  = r_rd[1];
   assign mem_cs      = r_cs;
   assign mem_page    = r_page;
   assign mem_offset  = r_offset;
   assign mem_wr_en   = r_wr_en;
   assign mem_wr_data = r_wdata;
   assign mem_wr_msk  = r_wmsk;
   assign mem_rd_en   = r_rd_en;
   assign busy        = r_busy;
   assign grant       = r_grant;
endmodule

// File: tb/tb_helm_mem_arb.sv
// tb_helm_mem_arb: directed stimulus for helm_mem_arb, checked every cycle against a
// timestamp-based transaction model plus literal expectations.
module tb_helm_mem_arb;
   localparam int TC = 8;
   logic       clk = 1'b0, rst = 1'b1;
   logic       m0_req = 0, m0_wr = 0, m1_req = 0, m1_wr = 0;
   logic [7:0] m0_page = 0, m0_offset = 0, m0_wr_data = 0, m0_wr_msk = 0;
   logic [7:0] m1_page = 0, m1_offset = 0, m1_wr_data = 0, m1_wr_msk = 0;
   logic       m0_ack, m0_err, m1_ack, m1_err;
   logic [7:0] m0_rd_data, m1_rd_data;
   logic       mem_cs, mem_wr_en, mem_rd_en, busy, grant;
   logic [7:0] mem_page, mem_offset, mem_wr_data, mem_wr_msk;
   logic       resp_ack = 0, spur_ack = 0;
   logic [7:0] resp_data = 0, spur_data = 0;
   int         resp_lat = 0;
   logic       mem_ack;
   logic [7:0] mem_rd_data;
   assign mem_ack     = resp_ack | spur_ack;
   assign mem_rd_data = spur_ack ? spur_data : resp_data;

   helm_mem_arb #(.TIMEOUT_CYC(TC), .TO_CNT_BIT(16), .TO_RD_DATA(8'hFF)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_wr(m0_wr), .m0_page(m0_page), .m0_offset(m0_offset),
      .m0_wr_data(m0_wr_data), .m0_wr_msk(m0_wr_msk), .m0_ack(m0_ack), .m0_err(m0_err),
      .m0_rd_data(m0_rd_data),
      .m1_req(m1_req), .m1_wr(m1_wr), .m1_page(m1_page), .m1_offset(m1_offset),
      .m1_wr_data(m1_wr_data), .m1_wr_msk(m1_wr_msk), .m1_ack(m1_ack), .m1_err(m1_err),
      .m1_rd_data(m1_rd_data),
      .mem_cs(mem_cs), .mem_page(mem_page), .mem_offset(mem_offset), .mem_wr_en(mem_wr_en),
      .mem_wr_data(mem_wr_data), .mem_wr_msk(mem_wr_msk), .mem_rd_en(mem_rd_en),
      .mem_rd_data(mem_rd_data), .mem_ack(mem_ack), .busy(busy), .grant(grant)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // transaction model: remembers the edge a request was granted and the edge it completed
   int         cyc = 0, t0 = 0, t_ack = -1;
   bit         m_busy = 0, own = 0, last_g = 1, m_wr = 0, m_err = 0;
   logic [7:0] pg = 0, of = 0, wd = 0, wm = 0;
   logic [7:0] mrd [2];

   task automatic model_reset;
      m_busy = 0; last_g = 1; t_ack = -1;
      pg = 0; of = 0; wd = 0; wm = 0;
      mrd[0] = 0; mrd[1] = 0;
   endtask

   task automatic model_step;
      cyc++;
      if (!m_busy) begin
         if (m0_req || m1_req) begin
            own    = (m0_req && m1_req) ? !last_g : m1_req;
            last_g = own;
            m_busy = 1; t0 = cyc; t_ack = -1;
            m_wr = own ? m1_wr : m0_wr;
            pg   = own ? m1_page : m0_page;
            of   = own ? m1_offset : m0_offset;
            wd   = own ? m1_wr_data : m0_wr_data;
            wm   = own ? m1_wr_msk : m0_wr_msk;
         end
      end else if (t_ack < 0) begin
         if (cyc - t0 >= 2 && mem_ack) begin
            t_ack = cyc; m_err = 0;
            if (!m_wr) mrd[own] = mem_rd_data;
         end else if (cyc - t0 == TC + 2) begin
            t_ack = cyc; m_err = 1;
            if (!m_wr) mrd[own] = 8'hFF;
         end
      end else if (cyc == t_ack + 1) m_busy = 0;
   endtask

   task automatic compare_all;
      bit e_ack;
      e_ack = m_busy && t_ack == cyc;
      chk("busy", busy, m_busy);
      chk("grant", grant, last_g);
      chk("mem_cs", mem_cs, m_busy && t_ack < 0);
      chk("mem_wr_en", mem_wr_en, m_busy && cyc == t0 && m_wr);
      chk("mem_rd_en", mem_rd_en, m_busy && cyc == t0 && !m_wr);
      chk("mem_page", mem_page, pg);
      chk("mem_offset", mem_offset, of);
      chk("mem_wr_data", mem_wr_data, wd);
      chk("mem_wr_msk", mem_wr_msk, wm);
      chk("m0_ack", m0_ack, e_ack && !own);
      chk("m1_ack", m1_ack, e_ack && own);
      chk("m0_err", m0_err, e_ack && !own && m_err);
      chk("m1_err", m1_err, e_ack && own && m_err);
      chk("m0_rd_data", m0_rd_data, mrd[0]);
      chk("m1_rd_data", m1_rd_data, mrd[1]);
   endtask

   int          n_rdstb = 0, n_ack0 = 0, n_ack1 = 0;
   logic [16:0] slog [$];
   initial forever begin
      @(posedge clk);
      if (rst) model_reset(); else model_step();
      @(negedge clk);
      if (rst) model_reset();
      compare_all();
      if (mem_rd_en) n_rdstb++;
      if (m0_ack) n_ack0++;
      if (m1_ack) n_ack1++;
      if (mem_wr_en) slog.push_back({grant, mem_wr_data, mem_wr_msk});
   end

   // memory responder: acks resp_lat cycles after the strobe cycle, never when resp_lat is 0
   initial forever begin
      @(posedge clk);
      if ((mem_rd_en || mem_wr_en) && resp_lat > 0) begin
         repeat (resp_lat - 1) @(posedge clk);
         #1 resp_ack = 1;
         @(posedge clk);
         #1 resp_ack = 0;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(input bit p, input int maxc, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((p ? m1_ack : m0_ack) !== 1'b1 && n < maxc);
      if ((p ? m1_ack : m0_ack) !== 1'b1) begin
         n_cmp++; n_bad++;
         $display("FAIL wait_ack%0d: no ack within %0d cycles", p, maxc);
      end
   endtask

   task automatic wait_cs(input int maxc);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (mem_cs !== 1'b1 && n < maxc);
      if (mem_cs !== 1'b1) begin
         n_cmp++; n_bad++;
         $display("FAIL wait_cs: mem_cs not raised within %0d cycles", maxc);
      end
   endtask

   initial begin
      int n, na0, na1, nr;
      tick(2);
      chk("rst_grant", grant, 1);
      chk("rst_busy", busy, 0);
      chk("rst_cs", mem_cs, 0);
      rst = 0;
      tick(2);
      // both ports hold writes: ownership must alternate starting with port 0
      slog.delete();
      m0_wr = 1; m0_page = 8'h02; m0_offset = 8'h00; m0_wr_data = 8'h11; m0_wr_msk = 8'hFF;
      m1_wr = 1; m1_page = 8'h03; m1_offset = 8'h04; m1_wr_data = 8'h22; m1_wr_msk = 8'h0F;
      resp_lat = 1; m0_req = 1; m1_req = 1;
      for (int i = 0; i < 4; i++) wait_ack(i[0], 20, n);
      tick(1);
      m0_req = 0; m1_req = 0;
      tick(3);
      chk("wr_strobes", slog.size(), 4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("wr_log%0d", i), (i < slog.size()) ? slog[i] : 17'h1FFFF,
             {i[0], i[0] ? 8'h22 : 8'h11, i[0] ? 8'h0F : 8'hFF});
      // single read on port 0
      resp_lat = 2; resp_data = 8'h5A;
      m0_wr = 0; m0_page = 8'h01; m0_offset = 8'h10;
      na0 = n_ack0; na1 = n_ack1; nr = n_rdstb;
      m0_req = 1;
      wait_ack(0, 20, n);
      chk("t1_rd", m0_rd_data, 8'h5A);
      chk("t1_err", m0_err, 0);
      tick(1);
      m0_req = 0;
      tick(3);
      chk("t1_acks0", n_ack0 - na0, 1);
      chk("t1_acks1", n_ack1 - na1, 0);
      chk("t1_rdstb", n_rdstb - nr, 1);
      chk("t1_page", mem_page, 8'h01);
      chk("t1_off", mem_offset, 8'h10);
      chk("t1_hold", m0_rd_data, 8'h5A);
      // port 1 read times out
      resp_lat = 0;
      m1_wr = 0; m1_page = 8'h05; m1_offset = 8'h06;
      m1_req = 1;
      wait_cs(20);
      wait_ack(1, 30, n);
      chk("t3_lat", n, 10);
      chk("t3_err", m1_err, 1);
      chk("t3_rd", m1_rd_data, 8'hFF);
      tick(1);
      m1_req = 0;
      tick(1);
      chk("t3_busy", busy, 0);
      // spurious acks in IDLE and ISSUE, real one in WAIT
      na0 = n_ack0;
      m0_wr = 0; m0_page = 8'h07; m0_offset = 8'h08;
      spur_data = 8'hEE; spur_ack = 1;
      tick(1);
      spur_ack = 0; m0_req = 1;
      tick(1);
      spur_ack = 1;
      tick(1);
      spur_ack = 0;
      tick(1);
      spur_data = 8'h3C; spur_ack = 1;
      tick(1);
      spur_ack = 0;
      wait_ack(0, 20, n);
      tick(1);
      m0_req = 0;
      tick(3);
      chk("t4_rd", m0_rd_data, 8'h3C);
      chk("t4_acks", n_ack0 - na0, 1);
      // requester drops req during ISSUE
      resp_lat = 2; resp_data = 8'h77;
      m0_page = 8'h09; m0_offset = 8'h0A;
      na0 = n_ack0;
      m0_req = 1;
      tick(1);
      m0_req = 0;
      wait_ack(0, 20, n);
      tick(3);
      chk("t6_rd", m0_rd_data, 8'h77);
      chk("t6_acks", n_ack0 - na0, 1);
      // reset during WAIT of a port-0 read
      resp_lat = 0;
      m0_page = 8'h0B; m0_offset = 8'h0C;
      na0 = n_ack0;
      m0_req = 1;
      tick(3);
      #1 rst = 1;
      #1;
      chk("t5_cs", mem_cs, 0);
      chk("t5_busy", busy, 0);
      chk("t5_ack", m0_ack, 0);
      chk("t5_rd", m0_rd_data, 0);
      chk("t5_grant", grant, 1);
      m0_req = 0;
      tick(1);
      rst = 0;
      tick(1);
      chk("t5_noack", n_ack0 - na0, 0);
      resp_lat = 1; resp_data = 8'h42;
      m0_page = 8'h0D; m1_page = 8'h0E;
      m0_req = 1; m1_req = 1;
      wait_cs(10);
      chk("t5_tie", grant, 0);
      wait_ack(0, 20, n);
      tick(1);
      m0_req = 0;
      wait_ack(1, 20, n);
      tick(1);
      m1_req = 0;
      tick(3);
      chk("t5_rd0", m0_rd_data, 8'h42);
      chk("t5_rd1", m1_rd_data, 8'h42);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
